// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed display scanner with dead time per slot and a
// shadow register that commits new values only at frame boundaries.
module seg_scan_ctrl #(
   parameter int unsigned SCAN_DIV = 100000,
   parameter int unsigned DEAD     = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] data_in,
   input  logic [7:0]  blank_in,
   output logic [7:0]  led_id,
   output logic [3:0]  digit,
   output logic        blank,
   output logic        frame_done
);

   localparam int unsigned PcW = $clog2(SCAN_DIV);
   localparam logic [PcW-1:0] PcLast  = PcW'(SCAN_DIV - 1);
   localparam logic [PcW-1:0] DeadCnt = PcW'(DEAD);

   logic [PcW-1:0] pc_q, pc_d;
   logic [2:0]     idx_q, idx_d;
   logic [31:0]    disp_data_q, disp_data_d;
   logic [7:0]     disp_blank_q, disp_blank_d;
   logic [31:0]    sh_data_q, sh_data_d;
   logic [7:0]     sh_blank_q, sh_blank_d;
   logic           pending_q, pending_d;

   logic slot_end;
   logic boundary;
   logic accept;
   logic commit;
   logic in_dead;

   always_comb begin
      slot_end = (pc_q == PcLast);
      boundary = en & slot_end & (idx_q == 3'd7);
      in_ready = rst_n & ~pending_q;
      accept   = in_valid & in_ready;
      // accept needs pending=0, so a value taken on the boundary waits a frame
      commit   = pending_q & (~en | boundary);
      in_dead  = (pc_q < DeadCnt);
   end

   always_comb begin
      pc_d         = pc_q;
      idx_d        = idx_q;
      disp_data_d  = disp_data_q;
      disp_blank_d = disp_blank_q;
      sh_data_d    = sh_data_q;
      sh_blank_d   = sh_blank_q;
      pending_d    = pending_q;

      if (!en) begin
         pc_d  = '0;
         idx_d = 3'd0;
      end else if (slot_end) begin
         pc_d  = '0;
         idx_d = idx_q + 3'd1;
      end else begin
         pc_d = pc_q + 1'b1;
      end

      if (commit) begin
         disp_data_d  = sh_data_q;
         disp_blank_d = sh_blank_q;
         pending_d    = 1'b0;
      end

      if (accept) begin
         sh_data_d  = data_in;
         sh_blank_d = blank_in;
         pending_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= '0;
         idx_q        <= 3'd0;
         disp_data_q  <= 32'h0;
         disp_blank_q <= 8'h0;
         sh_data_q    <= 32'h0;
         sh_blank_q   <= 8'h0;
         pending_q    <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         idx_q        <= idx_d;
         disp_data_q  <= disp_data_d;
         disp_blank_q <= disp_blank_d;
         sh_data_q    <= sh_data_d;
         sh_blank_q   <= sh_blank_d;
         pending_q    <= pending_d;
      end
   end

   // Outputs are gated by rst_n so the dark state holds during reset whatever DEAD is.
   always_comb begin
      led_id     = 8'hFF;
      blank      = 1'b1;
      frame_done = 1'b0;
      digit      = 4'h0;
      if (rst_n) begin
         digit = disp_data_q[{idx_q, 2'b00} +: 4];
         if (en) begin
            led_id     = in_dead ? 8'hFF : ~(8'b1 << idx_q);
            blank      = disp_blank_q[idx_q] | in_dead;
            frame_done = boundary;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl at SCAN_DIV=4, DEAD=1: per-frame expected output
// sequences are queued from the load values and compared cycle by cycle.
module tb_seg_scan_ctrl;

   localparam int unsigned SCAN_DIV = 4;
   localparam int unsigned DEAD     = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] data_in;
   logic [7:0]  blank_in;
   logic [7:0]  led_id;
   logic [3:0]  digit;
   logic        blank;
   logic        frame_done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [13:0] sb[$];
   logic [13:0] exp_v;

   seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEAD(DEAD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .blank_in  (blank_in),
      .led_id    (led_id),
      .digit     (digit),
      .blank     (blank),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected {led_id, digit, blank, frame_done} for one frame, slot by slot.
   task automatic push_frame(input logic [31:0] d, input logic [7:0] b);
      logic [7:0] led;
      for (int k = 0; k < 8; k++) begin
         for (int c = 0; c < int'(SCAN_DIV); c++) begin
            led = (c < int'(DEAD)) ? 8'hFF : ~(8'h01 << k);
            sb.push_back({led, d[4*k +: 4], b[k] | (c < int'(DEAD)),
                          (k == 7) && (c == int'(SCAN_DIV) - 1)});
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; data_in = '0; blank_in = '0;
      #12;
      n_tests++;
      if ({led_id, digit, blank, frame_done, in_ready} !== {8'hFF, 4'h0, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_outputs got %h exp %h", {led_id, digit, blank, frame_done, in_ready},
                  {8'hFF, 4'h0, 1'b1, 1'b0, 1'b0});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready got %b exp 1", in_ready);
      end
   endtask

   task automatic test_load_scan();
      bit found = 0;
      en = 1'b1; in_valid = 1'b1; data_in = 32'h76543210; blank_in = 8'h00;
      step();
      in_valid = 1'b0;
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL load_pending_ready got %b exp 0", in_ready);
      end
      for (int i = 0; i < 40; i++) begin
         if (frame_done === 1'b1) begin
            found = 1;
            break;
         end
         step();
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL load_frame_done got none exp pulse within 40 cycles");
      end
      step();
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL load_commit_ready got %b exp 1", in_ready);
      end
      push_frame(32'h76543210, 8'h00);
      for (int i = 0; i < 32; i++) begin
         exp_v = sb.pop_front();
         n_tests++;
         if ({led_id, digit, blank, frame_done} !== exp_v) begin
            n_fail++;
            $display("FAIL load_scan i=%0d got %h exp %h", i, {led_id, digit, blank, frame_done}, exp_v);
         end
         step();
      end
   endtask

   task automatic test_midframe_load();
      push_frame(32'h76543210, 8'h00);
      push_frame(32'hFEDCBA98, 8'h00);
      for (int i = 0; i < 64; i++) begin
         if (i == 10) begin
            in_valid = 1'b1; data_in = 32'hFEDCBA98; blank_in = 8'h00;
         end
         if (i == 11) begin
            in_valid = 1'b0;
            n_tests++;
            if (in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL midframe_ready_drop got %b exp 0", in_ready);
            end
         end
         if (i == 32) begin
            n_tests++;
            if (in_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL midframe_ready_back got %b exp 1", in_ready);
            end
         end
         exp_v = sb.pop_front();
         n_tests++;
         if ({led_id, digit, blank, frame_done} !== exp_v) begin
            n_fail++;
            $display("FAIL midframe_scan i=%0d got %h exp %h", i, {led_id, digit, blank, frame_done}, exp_v);
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      push_frame(32'hFEDCBA98, 8'h00);
      push_frame(32'hFEDCBA98, 8'h00);
      push_frame(32'hFFFFFFFF, 8'h00);
      for (int i = 0; i < 96; i++) begin
         if (i == 32) in_valid = 1'b0;
         if (i >= 32 && i < 64) begin
            n_tests++;
            if (in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL boundary_ready_low i=%0d got %b exp 0", i, in_ready);
            end
         end
         if (i == 64) begin
            n_tests++;
            if (in_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL boundary_ready_back got %b exp 1", in_ready);
            end
         end
         exp_v = sb.pop_front();
         n_tests++;
         if ({led_id, digit, blank, frame_done} !== exp_v) begin
            n_fail++;
            $display("FAIL boundary_scan i=%0d got %h exp %h", i, {led_id, digit, blank, frame_done}, exp_v);
         end
         if (i == 31) begin
            in_valid = 1'b1; data_in = 32'hFFFFFFFF; blank_in = 8'h00;
         end
         step();
      end
   endtask

   task automatic test_blank();
      push_frame(32'hFFFFFFFF, 8'h00);
      push_frame(32'h76543210, 8'hF0);
      for (int i = 0; i < 64; i++) begin
         if (i == 0) begin
            in_valid = 1'b1; data_in = 32'h76543210; blank_in = 8'hF0;
         end
         if (i == 1) in_valid = 1'b0;
         exp_v = sb.pop_front();
         n_tests++;
         if ({led_id, digit, blank, frame_done} !== exp_v) begin
            n_fail++;
            $display("FAIL blank_scan i=%0d got %h exp %h", i, {led_id, digit, blank, frame_done}, exp_v);
         end
         step();
      end
   endtask

   task automatic test_en_drop();
      push_frame(32'h76543210, 8'hF0);
      for (int i = 0; i < 21; i++) begin
         exp_v = sb.pop_front();
         n_tests++;
         if ({led_id, digit, blank, frame_done} !== exp_v) begin
            n_fail++;
            $display("FAIL endrop_scan i=%0d got %h exp %h", i, {led_id, digit, blank, frame_done}, exp_v);
         end
         step();
      end
      sb.delete();
      en = 1'b0;
      in_valid = 1'b1; data_in = 32'h13579BDF; blank_in = 8'h00;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++;
         if ({led_id, blank, frame_done} !== {8'hFF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL endrop_dark i=%0d got %h exp %h", i, {led_id, blank, frame_done},
                     {8'hFF, 1'b1, 1'b0});
         end
         if (i == 1) begin
            n_tests++;
            if (in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL endrop_pending got %b exp 0", in_ready);
            end
         end
         step();
         in_valid = 1'b0;
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL endrop_commit got %b exp 1", in_ready);
      end
      en = 1'b1;
      push_frame(32'h13579BDF, 8'h00);
      for (int i = 0; i < 32; i++) begin
         exp_v = sb.pop_front();
         n_tests++;
         if ({led_id, digit, blank, frame_done} !== exp_v) begin
            n_fail++;
            $display("FAIL enrestart_scan i=%0d got %h exp %h", i, {led_id, digit, blank, frame_done}, exp_v);
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; data_in = 32'h11111111; blank_in = 8'h00;
      step();
      in_valid = 1'b0;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({led_id, digit, blank, frame_done, in_ready} !== {8'hFF, 4'h0, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL midreset_outputs got %h exp %h", {led_id, digit, blank, frame_done, in_ready},
                  {8'hFF, 4'h0, 1'b1, 1'b0, 1'b0});
      end
      step();
      rst_n = 1'b1;
      #1;
      n_tests++;
      if ({in_ready, digit} !== {1'b1, 4'h0}) begin
         n_fail++;
         $display("FAIL midreset_release got %h exp %h", {in_ready, digit}, {1'b1, 4'h0});
      end
      push_frame(32'h0, 8'h00);
      push_frame(32'h0, 8'h00);
      for (int i = 0; i < 64; i++) begin
         exp_v = sb.pop_front();
         n_tests++;
         if ({led_id, digit, blank, frame_done} !== exp_v) begin
            n_fail++;
            $display("FAIL midreset_scan i=%0d got %h exp %h", i, {led_id, digit, blank, frame_done}, exp_v);
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_load_scan();
      test_midframe_load();
      test_back_to_back();
      test_blank();
      test_en_drop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
